// File: rtl/matmul_nxn_sys_wb_if.sv
// Bus bundle between the systolic matmul engine and its controller and A/B/C RAMs.
// The engine uses the master view; the wrapper or bench uses the slave view.
interface matmul_nxn_sys_wb_if #(
  parameter int N      = 4,
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
);
  logic                  start;
  logic                  acc_mode;
  logic                  sat_en;
  logic [AWIDTH-1:0]     a_base;
  logic [AWIDTH-1:0]     b_base;
  logic [AWIDTH-1:0]     c_base;
  logic [AWIDTH-1:0]     a_addr;
  logic [N*DWIDTH-1:0]   a_data;
  logic [AWIDTH-1:0]     b_addr;
  logic [N*DWIDTH-1:0]   b_data;
  logic [AWIDTH-1:0]     c_addr;
  logic [N*DWIDTH-1:0]   c_data;
  logic                  c_we;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, acc_mode, sat_en, a_base, b_base, c_base, a_data, b_data,
    output a_addr, b_addr, c_addr, c_data, c_we, busy, done
  );

  modport slave (
    output start, acc_mode, sat_en, a_base, b_base, c_base, a_data, b_data,
    input  a_addr, b_addr, c_addr, c_data, c_we, busy, done
  );
endinterface

// File: rtl/matmul_nxn_sys_wb.sv
// NxN output-stationary systolic matrix multiplier with its own A/B read sequencer
// and row-major C write-back (optionally saturating), C = A x B or C += A x B.
module matmul_nxn_sys_wb #(
  parameter int N         = 4,
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 7,
  parameter int ACC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  matmul_nxn_sys_wb_if.master bus
);

  localparam int CW = $clog2(2 * N);
  localparam int RW = $clog2(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [AWIDTH-1:0]   c_base_q;
  logic                sat_q;
  logic                feed_d;
  logic                take_start;
  logic                acc_clr;
  logic [RW-1:0]       row_sel;
  logic [N*DWIDTH-1:0] c_row_nxt;

  logic [DWIDTH-1:0]    a_west  [N];
  logic [DWIDTH-1:0]    b_north [N];
  logic [DWIDTH-1:0]    a_h     [N][N-1];
  logic [DWIDTH-1:0]    b_v     [N-1][N];
  logic [ACC_WIDTH-1:0] acc     [N][N];

  // busy is low in IDLE and DONE, so a start is accepted in either.
  assign take_start = bus.start && (state == S_IDLE || state == S_DONE);
  assign acc_clr    = take_start && !bus.acc_mode;

  function automatic logic [DWIDTH-1:0] wb_fn(input logic [ACC_WIDTH-1:0] x,
                                              input logic                 sat);
    if (sat && (|x[ACC_WIDTH-1:DWIDTH]))
      return '1;
    return x[DWIDTH-1:0];
  endfunction

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    row_sel   = (state == S_DRAIN) ? cnt[RW-1:0] + RW'(1) : '0;
    c_row_nxt = '0;
    for (int r = 0; r < N; r++) begin
      if (RW'(r) == row_sel) begin
        for (int j = 0; j < N; j++)
          c_row_nxt[j*DWIDTH +: DWIDTH] = wb_fn(acc[r][j], sat_q);
      end
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      c_base_q   <= '0;
      sat_q      <= 1'b0;
      feed_d     <= 1'b0;
      bus.a_addr <= '0;
      bus.b_addr <= '0;
      bus.c_addr <= '0;
      bus.c_data <= '0;
      bus.c_we   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.c_we <= 1'b0;
      bus.done <= 1'b0;
      feed_d   <= (state == S_FEED);
      case (state)
        S_IDLE, S_DONE: begin
          if (take_start) begin
            state      <= S_FEED;
            cnt        <= '0;
            bus.a_addr <= bus.a_base;
            bus.b_addr <= bus.b_base;
            c_base_q   <= bus.c_base;
            sat_q      <= bus.sat_en;
            bus.busy   <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FEED: begin
          if (cnt == CW'(N - 1)) begin
            state <= S_FLUSH;
            cnt   <= '0;
          end else begin
            cnt        <= cnt + CW'(1);
            bus.a_addr <= bus.a_addr + AWIDTH'(1);
            bus.b_addr <= bus.b_addr + AWIDTH'(1);
          end
        end
        S_FLUSH: begin
          // Row 0 is already final here, so its write is launched on this edge.
          if (cnt == CW'(2 * N - 2)) begin
            state      <= S_DRAIN;
            cnt        <= '0;
            bus.c_we   <= 1'b1;
            bus.c_addr <= c_base_q;
            bus.c_data <= c_row_nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == CW'(N - 1)) begin
            state    <= S_DONE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            cnt        <= cnt + CW'(1);
            bus.c_we   <= 1'b1;
            bus.c_addr <= bus.c_addr + AWIDTH'(1);
            bus.c_data <= c_row_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Input skew: lane i reaches the array i cycles late; zeros outside the read window.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DWIDTH-1:0] a_lane;
    logic [DWIDTH-1:0] b_lane;

    assign a_lane = feed_d ? bus.a_data[i*DWIDTH +: DWIDTH] : '0;
    assign b_lane = feed_d ? bus.b_data[i*DWIDTH +: DWIDTH] : '0;

    if (i == 0) begin : g_direct
      assign a_west[i]  = a_lane;
      assign b_north[i] = b_lane;
    end else begin : g_skew
      logic [DWIDTH-1:0] a_sr [i];
      logic [DWIDTH-1:0] b_sr [i];

      // NOTE: these register arrays are reset element by element because a
      // stale operand left in them after an abort would corrupt the next run.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= a_lane;
          b_sr[0] <= b_lane;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end

      assign a_west[i]  = a_sr[i-1];
      assign b_north[i] = b_sr[i-1];
    end
  end

  // PE grid: A flows right, B flows down, each PE keeps its own C element.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DWIDTH-1:0]    a_in;
      logic [DWIDTH-1:0]    b_in;
      logic [2*DWIDTH-1:0]  prod;
      logic [ACC_WIDTH-1:0] acc_r;

      if (j == 0) begin : g_a_edge
        assign a_in = a_west[i];
      end else begin : g_a_inner
        assign a_in = a_h[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = b_north[j];
      end else begin : g_b_inner
        assign b_in = b_v[i-1][j];
      end

      assign prod = {{DWIDTH{1'b0}}, a_in} * {{DWIDTH{1'b0}}, b_in};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          acc_r <= '0;
        else if (acc_clr)
          acc_r <= '0;
        else
          acc_r <= acc_r + ACC_WIDTH'(prod);
      end
      assign acc[i][j] = acc_r;

      if (j < N - 1) begin : g_a_pass
        logic [DWIDTH-1:0] a_r;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) a_r <= '0;
          else        a_r <= a_in;
        end
        assign a_h[i][j] = a_r;
      end

      if (i < N - 1) begin : g_b_pass
        logic [DWIDTH-1:0] b_r;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) b_r <= '0;
          else        b_r <= b_in;
        end
        assign b_v[i][j] = b_r;
      end
    end
  end

endmodule

// File: tb/tb_matmul_nxn_sys_wb.sv
// Directed bench for matmul_nxn_sys_wb (N=4): identity, constants, saturation,
// accumulate chaining, ignored mid-run start with address wrap, and mid-run reset.
module tb_matmul_nxn_sys_wb;
  localparam int N      = 4;
  localparam int DW     = 16;
  localparam int AW     = 7;
  localparam int ACCW   = 32;
  localparam int BUDGET = 4 * N + 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matmul_nxn_sys_wb_if #(.N(N), .DWIDTH(DW), .AWIDTH(AW)) bus ();

  matmul_nxn_sys_wb #(.N(N), .DWIDTH(DW), .AWIDTH(AW), .ACC_WIDTH(ACCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [N*DW-1:0] a_mem [2**AW];
  logic [N*DW-1:0] b_mem [2**AW];
  logic [N*DW-1:0] c_mem [2**AW];

  // Single-port RAMs with one-cycle read latency.
  always @(posedge clk) begin
    bus.a_data <= a_mem[bus.a_addr];
    bus.b_data <= b_mem[bus.b_addr];
  end

  int checks = 0;
  int errors = 0;

  int done_k, n_done, busy_n, nw, first_wr_k;
  logic [AW-1:0] wr_addr [8];
  logic [AW-1:0] a_at1, a_atn, a_hold, b_atn;

  logic [63:0] id_row [4];
  localparam logic [63:0] ALL_16 = 64'h0010_0010_0010_0010;
  localparam logic [63:0] ALL_FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALL_4  = 64'h0004_0004_0004_0004;
  localparam logic [63:0] ALL_8  = 64'h0008_0008_0008_0008;
  localparam logic [63:0] SENT   = 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_identity(input logic [AW-1:0] ab, input logic [AW-1:0] bb);
    for (int k = 0; k < N; k++) begin
      a_mem[AW'(ab + AW'(k))] = '0;
      a_mem[AW'(ab + AW'(k))][k*DW +: DW] = 16'd1;
      for (int j = 0; j < N; j++)
        b_mem[AW'(bb + AW'(k))][j*DW +: DW] = DW'(4 * k + j + 1);
    end
  endtask

  task automatic load_const(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                            input logic [DW-1:0] v);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        a_mem[AW'(ab + AW'(k))][j*DW +: DW] = v;
        b_mem[AW'(bb + AW'(k))][j*DW +: DW] = v;
      end
  endtask

  // One start pulse, then watch a fixed window; optional second start and reset.
  task automatic run(input logic acc_m, input logic sat, input logic [AW-1:0] ab,
                     input logic [AW-1:0] bb, input logic [AW-1:0] cb,
                     input int pulse_k, input int reset_k);
    for (int w = 0; w < 2**AW; w++) c_mem[w] = SENT;
    done_k = 0; n_done = 0; busy_n = 0; nw = 0; first_wr_k = 0;
    @(negedge clk);
    bus.acc_mode = acc_m;
    bus.sat_en   = sat;
    bus.a_base   = ab;
    bus.b_base   = bb;
    bus.c_base   = cb;
    bus.start    = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        n_done++;
        if (done_k == 0) done_k = k;
      end
      if (bus.c_we) begin
        if (nw == 0) first_wr_k = k;
        if (nw < 8) wr_addr[nw] = bus.c_addr;
        c_mem[bus.c_addr] = bus.c_data;
        nw++;
      end
      if (k == 1)     a_at1  = bus.a_addr;
      if (k == N)     begin a_atn = bus.a_addr; b_atn = bus.b_addr; end
      if (k == N + 3) a_hold = bus.a_addr;
      if (k == 1)           bus.start = 1'b0;
      if (k == pulse_k)     bus.start = 1'b1;
      if (k == pulse_k + 1) bus.start = 1'b0;
      if (k == reset_k) begin
        reset = 1'b0;
        #1;
        check("rst_mid_a_addr", 64'(bus.a_addr), 64'd0);
        check("rst_mid_b_addr", 64'(bus.b_addr), 64'd0);
        check("rst_mid_c_addr", 64'(bus.c_addr), 64'd0);
        check("rst_mid_c_data", bus.c_data, 64'd0);
        check("rst_mid_flags", {61'd0, bus.c_we, bus.busy, bus.done}, 64'd0);
      end
      if (k == reset_k + 3) reset = 1'b1;
    end
  endtask

  initial begin
    id_row[0] = 64'h0004_0003_0002_0001;
    id_row[1] = 64'h0008_0007_0006_0005;
    id_row[2] = 64'h000C_000B_000A_0009;
    id_row[3] = 64'h0010_000F_000E_000D;
    bus.start = 1'b0; bus.acc_mode = 1'b0; bus.sat_en = 1'b0;
    bus.a_base = '0; bus.b_base = '0; bus.c_base = '0;
    for (int w = 0; w < 2**AW; w++) begin
      a_mem[w] = '0; b_mem[w] = '0; c_mem[w] = '0;
    end

    // Reset state
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_addr", 64'(bus.a_addr), 64'd0);
    check("rst_b_addr", 64'(bus.b_addr), 64'd0);
    check("rst_c_addr", 64'(bus.c_addr), 64'd0);
    check("rst_c_data", bus.c_data, 64'd0);
    check("rst_flags", {61'd0, bus.c_we, bus.busy, bus.done}, 64'd0);
    reset = 1'b1;

    // Identity A, bases 0: C rows equal B rows
    load_identity(7'd0, 7'd0);
    run(1'b0, 1'b1, 7'd0, 7'd0, 7'd0, 0, 0);
    check("id_done_k", 64'(done_k), 64'd16);
    check("id_n_done", 64'(n_done), 64'd1);
    check("id_busy_n", 64'(busy_n), 64'd15);
    check("id_nw", 64'(nw), 64'd4);
    check("id_first_wr_k", 64'(first_wr_k), 64'd12);
    check("id_a_at1", 64'(a_at1), 64'd0);
    check("id_a_atn", 64'(a_atn), 64'd3);
    check("id_b_atn", 64'(b_atn), 64'd3);
    check("id_a_hold", 64'(a_hold), 64'd3);
    for (int r = 0; r < N; r++) begin
      check($sformatf("id_wr_addr%0d", r), 64'(wr_addr[r]), 64'(r));
      check($sformatf("id_c%0d", r), c_mem[r], id_row[r]);
    end

    // All 2 at nonzero bases: every element 16
    load_const(7'd8, 7'd16, 16'h0002);
    run(1'b0, 1'b1, 7'd8, 7'd16, 7'd32, 0, 0);
    check("two_a_at1", 64'(a_at1), 64'd8);
    check("two_b_atn", 64'(b_atn), 64'd19);
    check("two_busy_n", 64'(busy_n), 64'd15);
    check("two_done_k", 64'(done_k), 64'd16);
    check("two_wr_addr3", 64'(wr_addr[3]), 64'd35);
    for (int r = 0; r < N; r++)
      check($sformatf("two_c%0d", r), c_mem[32 + r], ALL_16);

    // 0x0100 operands: acc = 0x40000, saturated then truncated
    load_const(7'd8, 7'd16, 16'h0100);
    run(1'b0, 1'b1, 7'd8, 7'd16, 7'd40, 0, 0);
    for (int r = 0; r < N; r++)
      check($sformatf("sat_c%0d", r), c_mem[40 + r], ALL_FF);
    run(1'b0, 1'b0, 7'd8, 7'd16, 7'd40, 0, 0);
    for (int r = 0; r < N; r++)
      check($sformatf("trunc_c%0d", r), c_mem[40 + r], 64'd0);

    // Accumulate chaining with all-1 operands: 4, then 8, then cleared to 4
    load_const(7'd8, 7'd16, 16'h0001);
    run(1'b0, 1'b1, 7'd8, 7'd16, 7'd40, 0, 0);
    check("acc0_c0", c_mem[40], ALL_4);
    check("acc0_c3", c_mem[43], ALL_4);
    run(1'b1, 1'b1, 7'd8, 7'd16, 7'd40, 0, 0);
    check("acc1_c0", c_mem[40], ALL_8);
    check("acc1_c3", c_mem[43], ALL_8);
    run(1'b0, 1'b1, 7'd8, 7'd16, 7'd40, 0, 0);
    check("acc2_c0", c_mem[40], ALL_4);
    check("acc2_c3", c_mem[43], ALL_4);

    // Start pulsed mid-FLUSH is ignored; C address wraps 126,127,0,1
    load_identity(7'd0, 7'd0);
    run(1'b0, 1'b1, 7'd0, 7'd0, 7'd126, 7, 0);
    check("ign_nw", 64'(nw), 64'd4);
    check("ign_n_done", 64'(n_done), 64'd1);
    check("ign_done_k", 64'(done_k), 64'd16);
    check("ign_wr_addr0", 64'(wr_addr[0]), 64'd126);
    check("ign_wr_addr1", 64'(wr_addr[1]), 64'd127);
    check("ign_wr_addr2", 64'(wr_addr[2]), 64'd0);
    check("ign_wr_addr3", 64'(wr_addr[3]), 64'd1);
    check("ign_c126", c_mem[126], id_row[0]);
    check("ign_c127", c_mem[127], id_row[1]);
    check("ign_c0", c_mem[0], id_row[2]);
    check("ign_c1", c_mem[1], id_row[3]);

    // Reset during FEED cycle 2 aborts; a fresh start then works
    load_identity(7'd5, 7'd9);
    run(1'b0, 1'b1, 7'd5, 7'd9, 7'd20, 0, 3);
    check("abort_nw", 64'(nw), 64'd0);
    check("abort_n_done", 64'(n_done), 64'd0);
    check("abort_c20", c_mem[20], SENT);
    run(1'b0, 1'b1, 7'd5, 7'd9, 7'd20, 0, 0);
    check("fresh_done_k", 64'(done_k), 64'd16);
    check("fresh_nw", 64'(nw), 64'd4);
    for (int r = 0; r < N; r++)
      check($sformatf("fresh_c%0d", r), c_mem[20 + r], id_row[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
